// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates instruction fetches and data accesses onto one shared RAM port,
// with data-then-fetch alternation, error retry and a sticky access timeout flag.
module ram_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        tmo_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_data_q, last_data_d;
    logic          tmo_q, tmo_d;
    logic          dreq, req, done, fail, expire;

    assign dreq    = dREN | dWEN;
    assign req     = (state_q == DGRANT) ? dreq : (state_q == IGRANT) ? iREN : 1'b0;
    assign done    = req && (ramstate == RS_ACCESS);
    assign fail    = req && (ramstate == RS_ERROR);
    // cnt_q counts grant cycles already spent, so this cycle is number cnt_q+1
    assign expire  = req && !done && !fail && ((cnt_q + CW'(1)) == CW'(TIMEOUT));
    assign tmo_err = tmo_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_data_q <= last_data_d;
            tmo_q       <= tmo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        last_data_d = last_data_q;
        tmo_d       = tmo_q;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        case (state_q)
            IDLE: begin
                state_d = (dreq && !(last_data_q && iREN)) ? DGRANT : iREN ? IGRANT : IDLE;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~done;
                dload    = done ? ramload : '0;
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~done;
                iload   = done ? ramload : '0;
            end
            default: state_d = IDLE;
        endcase
        if (state_q == DGRANT || state_q == IGRANT) begin
            cnt_d       = cnt_q + CW'(1);
            state_d     = (!req || done || fail || expire) ? IDLE : state_q;
            last_data_d = done ? (state_q == DGRANT) : last_data_q;
            tmo_d       = tmo_q | expire;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table, hand-written corner sequences and a
// randomized run checked against an ownership-based reference model.
module tb_ram_arbiter;
    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'd0;
    logic        iwait, dwait, ramREN, ramWEN, tmo_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_chk = 0;
    int n_fail = 0;

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .iwait(iwait), .iload(iload), .dwait(dwait),
        .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate), .tmo_err(tmo_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  in;
        logic [1:0]  rs;
        logic [31:0] rl;
        logic [4:0]  ef;
        logic [31:0] il, dl, addr, store;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [4:0] flags();
        return {iwait, dwait, ramREN, ramWEN, tmo_err};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = 2'd0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // reference model: who owns the port, how long it has held it, alternation and timeout
    int          owner, age;
    logic        m_last, m_tmo, act;
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_il, e_dl, e_addr, e_store;

    task automatic model_outputs();
        if (!nRST) begin
            owner = 0; age = 0; m_last = 1'b0; m_tmo = 1'b0;
        end
        e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
        e_il = '0; e_dl = '0; e_addr = '0; e_store = '0; act = 1'b0;
        if (owner == 1) begin
            act = dREN | dWEN;
            e_wen = dWEN; e_ren = dREN & ~dWEN; e_addr = daddr; e_store = dstore;
            if (act && ramstate == 2'd2) begin e_dw = 1'b0; e_dl = ramload; end
        end else if (owner == 2) begin
            act = iREN;
            e_ren = iREN; e_addr = iaddr;
            if (act && ramstate == 2'd2) begin e_iw = 1'b0; e_il = ramload; end
        end
    endtask

    task automatic model_step();
        if (!nRST) return;
        if (owner == 0) begin
            if ((dREN | dWEN) && !(m_last && iREN)) begin owner = 1; age = 0; end
            else if (iREN) begin owner = 2; age = 0; end
        end else begin
            age++;
            if (!act) owner = 0;
            else if (ramstate == 2'd2) begin m_last = (owner == 1); owner = 0; end
            else if (ramstate == 2'd3) owner = 0;
            else if (age == TO) begin m_tmo = 1'b1; owner = 0; end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int grant;
        // {nRST,iREN,dREN,dWEN}, ramstate, ramload, {iwait,dwait,ramREN,ramWEN,tmo_err}, iload, dload, ramaddr, ramstore
        tbl[0]  = '{4'b0000, 2'd0, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[1]  = '{4'b1100, 2'd1, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[2]  = '{4'b1100, 2'd1, 32'h0,        5'b11100, 32'h0,        32'h0,        32'h40,  32'h0};
        tbl[3]  = '{4'b1100, 2'd1, 32'h0,        5'b11100, 32'h0,        32'h0,        32'h40,  32'h0};
        tbl[4]  = '{4'b1100, 2'd2, 32'h8C010004, 5'b01100, 32'h8C010004, 32'h0,        32'h40,  32'h0};
        tbl[5]  = '{4'b1000, 2'd0, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[6]  = '{4'b1101, 2'd1, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[7]  = '{4'b1101, 2'd2, 32'h12345678, 5'b10010, 32'h0,        32'h12345678, 32'h100, 32'hDEADBEEF};
        tbl[8]  = '{4'b1110, 2'd1, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[9]  = '{4'b1110, 2'd2, 32'hCAFEF00D, 5'b01100, 32'hCAFEF00D, 32'h0,        32'h40,  32'h0};
        tbl[10] = '{4'b1010, 2'd1, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[11] = '{4'b1010, 2'd1, 32'h0,        5'b11100, 32'h0,        32'h0,        32'h100, 32'hDEADBEEF};
        tbl[12] = '{4'b1000, 2'd2, 32'h77,       5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[13] = '{4'b1010, 2'd3, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[14] = '{4'b1010, 2'd3, 32'h0,        5'b11100, 32'h0,        32'h0,        32'h100, 32'hDEADBEEF};
        tbl[15] = '{4'b1010, 2'd1, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[16] = '{4'b1010, 2'd2, 32'h55AA,     5'b10100, 32'h0,        32'h55AA,     32'h100, 32'hDEADBEEF};
        tbl[17] = '{4'b1000, 2'd0, 32'h0,        5'b11000, 32'h0,        32'h0,        32'h0,   32'h0};

        iaddr = 32'h40; daddr = 32'h100; dstore = 32'hDEADBEEF;
        for (int i = 0; i < 18; i++) begin
            @(negedge CLK);
            {nRST, iREN, dREN, dWEN} = tbl[i].in;
            ramstate = tbl[i].rs;
            ramload = tbl[i].rl;
            #1;
            chk($sformatf("row%0d flags{iw,dw,ren,wen,tmo}", i), 32'(flags()), 32'(tbl[i].ef));
            chk($sformatf("row%0d iload", i), iload, tbl[i].il);
            chk($sformatf("row%0d dload", i), dload, tbl[i].dl);
            if (tbl[i].ef[2] | tbl[i].ef[1]) begin
                chk($sformatf("row%0d ramaddr", i), ramaddr, tbl[i].addr);
                chk($sformatf("row%0d ramstore", i), ramstore, tbl[i].store);
            end
        end

        // timeout with RAM stuck BUSY
        do_reset();
        dREN = 1'b1; ramstate = 2'd1;
        grant = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK); #1;
            if (ramREN) grant++;
            else if (grant > 0) break;
        end
        chk("timeout grant cycles", 32'(grant), 32'd15);
        chk("tmo_err after timeout", 32'(tmo_err), 32'd1);
        chk("dwait during timeout", 32'(dwait), 32'd1);
        repeat (5) @(negedge CLK);
        #1 chk("tmo_err sticky under regrant", 32'(tmo_err), 32'd1);
        dREN = 1'b0; ramstate = 2'd0;
        repeat (3) @(negedge CLK);
        #1 chk("tmo_err sticky idle", 32'(tmo_err), 32'd1);
        nRST = 1'b0;
        #1 chk("tmo_err cleared by reset", 32'(tmo_err), 32'd0);

        // reset during a data write grant
        @(negedge CLK);
        nRST = 1'b1; dWEN = 1'b1; ramstate = 2'd1;
        @(negedge CLK); #1;
        @(negedge CLK); #1 chk("write granted before reset", 32'({ramREN, ramWEN}), 32'b01);
        #2 nRST = 1'b0;
        #1 chk("reset mid-grant flags", 32'(flags()), 32'b11000);
        chk("reset mid-grant dload", dload, 32'h0);
        @(negedge CLK);
        nRST = 1'b1; dWEN = 1'b0; ramstate = 2'd2; ramload = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); #1 chk($sformatf("no completion after reset %0d", k), 32'({dwait, iwait}), 32'b11);
        end
        iREN = 1'b1; dWEN = 1'b1; ramstate = 2'd1;
        @(negedge CLK); #1;
        @(negedge CLK); #1 chk("first grant after reset is data", 32'({ramREN, ramWEN}), 32'b01);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            nRST = (c == 0) ? 1'b0 : (!nRST) ? 1'b1 : ($urandom_range(0, 149) != 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            if ((c % 250) < 40) begin
                iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; ramstate = 2'd1;
            end else begin
                int r;
                iREN = ($urandom_range(0, 9) < 6);
                dREN = ($urandom_range(0, 9) < 4);
                dWEN = ($urandom_range(0, 9) < 3);
                r = $urandom_range(0, 9);
                ramstate = (r < 5) ? 2'd1 : (r == 5) ? 2'd0 : (r < 9) ? 2'd2 : 2'd3;
            end
            #1;
            model_outputs();
            chk($sformatf("rand%0d flags{iw,dw,ren,wen,tmo}", c), 32'(flags()),
                32'({e_iw, e_dw, e_ren, e_wen, m_tmo}));
            chk($sformatf("rand%0d iload", c), iload, e_il);
            chk($sformatf("rand%0d dload", c), dload, e_dl);
            if (e_ren | e_wen) begin
                chk($sformatf("rand%0d ramaddr", c), ramaddr, e_addr);
                chk($sformatf("rand%0d ramstore", c), ramstore, e_store);
            end
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles a granted access waits for ramstate==ACCESS before abort.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 iREN  in  1  instruction read request; iaddr  in  32  instruction word address.
REQ-005 dREN  in  1  data read request; dWEN  in  1  data write request; daddr  in  32  data address; dstore  in  32  write data.
REQ-006 iwait  out  1  low only in the cycle instruction read data is valid; iload  out  32  instruction read data.
REQ-007 dwait  out  1  low only in the cycle a data access completes; dload  out  32  data read data.
REQ-008 ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32  single shared RAM port.
REQ-009 ramload  in  32  RAM read data; ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-010 tmo_err  out  1  sticky flag, set when any access times out.

Function
REQ-011 FSM states SHALL be IDLE, DGRANT, IGRANT.
REQ-012 IDLE: ramREN=ramWEN=0, iwait=dwait=1; next state chosen from requests sampled this cycle (one-cycle arbitration latency).
REQ-013 IDLE->DGRANT when (dREN|dWEN) and not (last_was_data and iREN); IDLE->IGRANT when iREN and (no data request or last_was_data).
REQ-014 last_was_data bit SHALL be set on DGRANT completion, cleared on IGRANT completion; prevents fetch starvation by back-to-back data accesses.
REQ-015 DGRANT: ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted).
REQ-016 IGRANT: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
REQ-017 In a grant state with ramstate==ACCESS: matching wait SHALL go low combinationally that cycle, load output = ramload, FSM returns to IDLE next edge.
REQ-018 ramstate==ERROR in a grant state: no completion, wait stays 1, FSM returns to IDLE (request re-arbitrated, i.e. retried).
REQ-019 Cycle counter cleared on entry to a grant state, increments each grant cycle without ACCESS; reaching TIMEOUT SHALL force IDLE next edge and set tmo_err.
REQ-020 Request withdrawn in grant state (DGRANT with dREN=dWEN=0, or IGRANT with iREN=0): RAM enables drop same cycle, FSM returns to IDLE, no completion signalled.
REQ-021 iload, dload SHALL be 0 whenever their wait is 1.
REQ-022 Non-granted requester's wait SHALL remain 1 throughout another's grant.
REQ-023 Counter width SHALL be $clog2(TIMEOUT+1) bits; no wrap before TIMEOUT.

Reset
REQ-024 nRST low SHALL immediately force IDLE, counter=0, last_was_data=0, tmo_err=0, ramREN=ramWEN=0, iwait=dwait=1, iload=dload=0, regardless of state.
REQ-025 Reset asserted mid-grant SHALL abort the access with no completion; first grant after release follows REQ-013 with last_was_data=0.

Verification
REQ-026 iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS, ramload=0x8C010004 -> ramREN=1, ramaddr=0x40 from cycle 2; iwait=0, iload=0x8C010004 in ACCESS cycle only.
REQ-027 iREN=1 and dWEN=1 together, daddr=0x100, dstore=0xDEADBEEF -> DGRANT first (ramWEN=1, ramstore=0xDEADBEEF), then IGRANT even if dREN re-asserted.
REQ-028 ramstate held BUSY with dREN=1, TIMEOUT=15 -> exit to IDLE after 15 grant cycles, tmo_err=1 and stays 1 until nRST.
REQ-029 ramstate=ERROR once then ACCESS on retry -> no dwait pulse on error, single dwait=0 pulse on retry completion.
REQ-030 nRST pulsed low during DGRANT with ramWEN=1 -> ramWEN=0 and dwait=1 immediately; no completion after release until new arbitration.
REQ-031 dREN dropped mid-DGRANT -> ramREN=0 same cycle, IDLE next edge, dwait never low.
